udp_rx_deframer: RTL and testbench

UDP_RX_DEFRAMER -- requirements
Module: udp_rx_deframer

---
 rtl/udp_pkg.sv | 29 ++
 rtl/udp_payload_fifo.sv | 52 +++++
 rtl/udp_rx_deframer.sv | 158 +++++++++++++++
 tb/tb_udp_rx_deframer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// ---------------------------------------------------------------------------
// udp_pkg: shared FSM encoding and UDP header layout for udp_rx_deframer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package udp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  // Big-endian byte offsets within the 8-byte UDP header.
  localparam logic [2:0] OFF_SRC_HI  = 3'd0;
  localparam logic [2:0] OFF_SRC_LO  = 3'd1;
  localparam logic [2:0] OFF_DST_HI  = 3'd2;
  localparam logic [2:0] OFF_DST_LO  = 3'd3;
  localparam logic [2:0] OFF_LEN_HI  = 3'd4;
  localparam logic [2:0] OFF_LEN_LO  = 3'd5;
  localparam logic [2:0] OFF_CSUM_HI = 3'd6;
  localparam logic [2:0] OFF_CSUM_LO = 3'd7;

endpackage

`default_nettype wire

// File: rtl/udp_payload_fifo.sv
// ---------------------------------------------------------------------------
// udp_payload_fifo: synchronous 9-bit FIFO (data + last), show-ahead read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module udp_payload_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [8:0] wr_data,
  input  logic       rd_en,
  output logic [8:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       wr_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_rd;
  logic        do_wr;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign wr_drop = wr_en && full && !do_rd;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/udp_rx_deframer.sv
// ---------------------------------------------------------------------------
// udp_rx_deframer: parses UDP header, streams payload through a FIFO.
// Optional destination-port filter: UDP_PORT_FILTER_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module udp_rx_deframer
  import udp_pkg::*;
#(
  parameter logic [15:0] DST_PORT   = 16'd5000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        main_clk,
  input  logic        main_rst,
  input  logic [7:0]  udp_byte,
  input  logic        valid_udp,
  input  logic        input_ready,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] pay_len,
  output logic        hdr_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        err_len,
  output logic        err_trunc,
  output logic        err_ovf
);

  state_t      state;
  logic [2:0]  hdr_cnt;
  logic [15:0] src_sh;
  logic [15:0] dst_sh;
  logic [15:0] len_sh;
  logic [15:0] pay_cnt;
  logic [15:0] pay_cnt_nxt;
  logic        pay_last;
  logic        port_ok;
  logic        fifo_wr;
  logic [8:0]  fifo_rd;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_drop;

`ifdef UDP_PORT_FILTER_EN
  assign port_ok = (dst_sh == DST_PORT);
`else
  logic unused_dst_port;
  assign port_ok         = 1'b1;
  assign unused_dst_port = ^DST_PORT;
`endif

  assign pay_cnt_nxt = pay_cnt + 16'd1;
  assign pay_last    = (pay_cnt_nxt == pay_len);
  assign fifo_wr     = (state == PAYLOAD) && input_ready && valid_udp;

  udp_payload_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (main_clk),
    .rst     (main_rst),
    .wr_en   (fifo_wr),
    .wr_data ({pay_last, udp_byte}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .wr_drop (fifo_drop)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 8'h00 : fifo_rd[7:0];
  assign out_last  = !fifo_empty && fifo_rd[8];

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      state     <= IDLE;
      hdr_cnt   <= '0;
      src_sh    <= '0;
      dst_sh    <= '0;
      len_sh    <= '0;
      pay_cnt   <= '0;
      src_port  <= '0;
      dst_port  <= '0;
      pay_len   <= '0;
      hdr_valid <= 1'b0;
      err_len   <= 1'b0;
      err_trunc <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      err_len   <= 1'b0;
      err_trunc <= 1'b0;
      err_ovf   <= fifo_drop;
      if (input_ready) begin
        case (state)
          IDLE: begin
            if (valid_udp) begin
              src_sh[15:8] <= udp_byte;
              hdr_cnt      <= OFF_SRC_LO;
              state        <= HDR;
            end
          end
          HDR: begin
            if (!valid_udp) begin
              err_trunc <= 1'b1;
              state     <= IDLE;
            end else begin
              hdr_cnt <= hdr_cnt + 3'd1;
              case (hdr_cnt)
                OFF_SRC_LO: src_sh[7:0]  <= udp_byte;
                OFF_DST_HI: dst_sh[15:8] <= udp_byte;
                OFF_DST_LO: dst_sh[7:0]  <= udp_byte;
                OFF_LEN_HI: len_sh[15:8] <= udp_byte;
                OFF_LEN_LO: len_sh[7:0]  <= udp_byte;
                OFF_CSUM_LO: begin
                  // Checksum bytes are consumed but never stored.
                  if (len_sh < UDP_HDR_LEN) begin
                    err_len <= 1'b1;
                    state   <= DROP;
                  end else if (!port_ok) begin
                    state <= DROP;
                  end else begin
                    hdr_valid <= 1'b1;
                    src_port  <= src_sh;
                    dst_port  <= dst_sh;
                    pay_len   <= len_sh - UDP_HDR_LEN;
                    pay_cnt   <= '0;
                    state     <= (len_sh == UDP_HDR_LEN) ? DROP : PAYLOAD;
                  end
                end
                default: ;
              endcase
            end
          end
          PAYLOAD: begin
            if (!valid_udp) begin
              err_trunc <= 1'b1;
              state     <= IDLE;
            end else begin
              // Keep counting even when the FIFO drops the byte.
              pay_cnt <= pay_cnt_nxt;
              if (pay_last) state <= DROP;
            end
          end
          DROP: begin
            if (!valid_udp) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_udp_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_udp_rx_deframer: directed stimulus with queue scoreboard and output monitor. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_udp_rx_deframer;
  import udp_pkg::*;

  logic        main_clk = 1'b0;
  logic        main_rst;
  logic [7:0]  udp_byte;
  logic        valid_udp;
  logic        input_ready;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [15:0] pay_len;
  logic        hdr_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        err_len;
  logic        err_trunc;
  logic        err_ovf;

  int checks   = 0;
  int failures = 0;

  logic [47:0] hdr_q [$];
  logic [8:0]  pay_q [$];
  int          err_q [$];
  logic [7:0]  pl    [$];

  logic [47:0] exp_hdr;
  logic [8:0]  exp_pay;
  int          exp_err;

  udp_rx_deframer #(
    .DST_PORT   (16'd5000),
    .FIFO_DEPTH (16)
  ) dut (
    .main_clk    (main_clk),
    .main_rst    (main_rst),
    .udp_byte    (udp_byte),
    .valid_udp   (valid_udp),
    .input_ready (input_ready),
    .src_port    (src_port),
    .dst_port    (dst_port),
    .pay_len     (pay_len),
    .hdr_valid   (hdr_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .err_len     (err_len),
    .err_trunc   (err_trunc),
    .err_ovf     (err_ovf)
  );

  always #5 main_clk = ~main_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  task automatic push_hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    hdr_q.push_back({s, d, l});
  endtask

  task automatic push_pay(input logic last, input logic [7:0] d);
    pay_q.push_back({last, d});
  endtask

  task automatic pop_err(input int code);
    if (err_q.size() == 0) begin
      unexpected("err_pulse", code);
    end else begin
      exp_err = err_q.pop_front();
      check("err_code", code, exp_err);
    end
  endtask

  // Monitor: samples on the falling edge, midway between active edges.
  always @(negedge main_clk) begin
    if (!main_rst) begin
      if (hdr_valid) begin
        if (hdr_q.size() == 0) begin
          unexpected("hdr_valid", {src_port, dst_port, pay_len});
        end else begin
          exp_hdr = hdr_q.pop_front();
          check("hdr_src", src_port, exp_hdr[47:32]);
          check("hdr_dst", dst_port, exp_hdr[31:16]);
          check("hdr_pay_len", pay_len, exp_hdr[15:0]);
        end
      end
      if (out_valid && out_ready) begin
        if (pay_q.size() == 0) begin
          unexpected("payload_out", {out_last, out_data});
        end else begin
          exp_pay = pay_q.pop_front();
          check("payload_last_data", {out_last, out_data}, exp_pay);
        end
      end
      if (err_len)   pop_err(1);
      if (err_trunc) pop_err(2);
      if (err_ovf)   pop_err(3);
    end
  end

  task automatic drive(input logic [7:0] b, input logic v, input logic ir);
    udp_byte    = b;
    valid_udp   = v;
    input_ready = ir;
    @(posedge main_clk);
    #1;
  endtask

  task automatic send_hdr(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    drive(s[15:8], 1'b1, 1'b1);
    drive(s[7:0],  1'b1, 1'b1);
    drive(d[15:8], 1'b1, 1'b1);
    drive(d[7:0],  1'b1, 1'b1);
    drive(l[15:8], 1'b1, 1'b1);
    drive(l[7:0],  1'b1, 1'b1);
    drive(8'h00,   1'b1, 1'b1);
    drive(8'h00,   1'b1, 1'b1);
  endtask

  // Optional stall cycle after each byte exercises input_ready low.
  task automatic send_pl(input logic gap);
    foreach (pl[i]) begin
      drive(pl[i], 1'b1, 1'b1);
      if (gap) drive(8'hC3, 1'b1, 1'b0);
    end
  endtask

  task automatic end_frame();
    repeat (3) drive(8'h00, 1'b0, 1'b1);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 200 && (pay_q.size() + hdr_q.size() + err_q.size()) != 0; i++)
      @(posedge main_clk);
    #1;
    check({name, "_hdr_left"}, hdr_q.size(), 0);
    check({name, "_pay_left"}, pay_q.size(), 0);
    check({name, "_err_left"}, err_q.size(), 0);
  endtask

  initial begin
    main_rst    = 1'b1;
    udp_byte    = 8'h00;
    valid_udp   = 1'b0;
    input_ready = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(posedge main_clk);
    #1;
    main_rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_ports_len", {src_port, dst_port, pay_len}, 0);
    check("rst_errs", {err_len, err_trunc, err_ovf}, 0);

    // Basic datagram with stalls between payload bytes.
    push_hdr(16'd1234, 16'd5000, 16'd4);
    push_pay(1'b0, 8'hDE);
    push_pay(1'b0, 8'hAD);
    push_pay(1'b0, 8'hBE);
    push_pay(1'b1, 8'hEF);
    send_hdr(16'd1234, 16'd5000, 16'd12);
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pl(1'b1);
    end_frame();
    wait_drained("basic");
    check("basic_pay_len_held", pay_len, 16'd4);

    // Length field below header size.
    err_q.push_back(1);
    send_hdr(16'd1, 16'd5000, 16'd5);
    pl = '{8'h55, 8'h66};
    send_pl(1'b0);
    end_frame();
    wait_drained("len5");

    // Header-only datagram followed by a normal one.
    push_hdr(16'd7, 16'd5000, 16'd0);
    send_hdr(16'd7, 16'd5000, 16'd8);
    end_frame();
    push_hdr(16'd8, 16'd5000, 16'd2);
    push_pay(1'b0, 8'h11);
    push_pay(1'b1, 8'h22);
    send_hdr(16'd8, 16'd5000, 16'd10);
    pl = '{8'h11, 8'h22};
    send_pl(1'b0);
    end_frame();
    wait_drained("len8");

    // Truncation after 5 of 12 payload bytes.
    push_hdr(16'd100, 16'd5000, 16'd12);
    for (int i = 1; i <= 5; i++) push_pay(1'b0, 8'(i));
    err_q.push_back(2);
    send_hdr(16'd100, 16'd5000, 16'd20);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pl(1'b0);
    end_frame();
    wait_drained("trunc");
    check("trunc_fsm_idle", dut.state, IDLE);

    // Overflow: 20 bytes into a 16-deep FIFO with the consumer stalled.
    out_ready = 1'b0;
    push_hdr(16'h4321, 16'd5000, 16'd20);
    for (int i = 0; i < 16; i++) push_pay(1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) err_q.push_back(3);
    send_hdr(16'h4321, 16'd5000, 16'd28);
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'(8'h40 + i));
    send_pl(1'b0);
    end_frame();
    check("ovf_full_valid", out_valid, 1);
    check("ovf_err_seen", err_q.size(), 0);
    out_ready = 1'b1;
    wait_drained("ovf");

    // Non-matching destination port.
`ifndef UDP_PORT_FILTER_EN
    push_hdr(16'd9, 16'd80, 16'd2);
    push_pay(1'b0, 8'hAA);
    push_pay(1'b1, 8'hBB);
`endif
    send_hdr(16'd9, 16'd80, 16'd10);
    pl = '{8'hAA, 8'hBB};
    send_pl(1'b0);
    end_frame();
    wait_drained("port80");

    // Reset in the middle of a header: no error pulse, fields cleared.
    drive(8'h12, 1'b1, 1'b1);
    drive(8'h34, 1'b1, 1'b1);
    drive(8'h13, 1'b1, 1'b1);
    drive(8'h88, 1'b1, 1'b1);
    main_rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    main_rst = 1'b0;
    check("midrst_src_port", src_port, 0);
    check("midrst_pay_len", pay_len, 0);
    check("midrst_fsm_idle", dut.state, IDLE);
    push_hdr(16'h0102, 16'd5000, 16'd1);
    push_pay(1'b1, 8'h77);
    send_hdr(16'h0102, 16'd5000, 16'd9);
    pl = '{8'h77};
    send_pl(1'b0);
    end_frame();
    wait_drained("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
